// File: rtl/led_frame_loader.sv
// led_frame_loader: assembles a G,R,B byte stream into a shadow buffer and
// commits complete frames atomically to the WS2812 driver data vector.
// Partial frames (restarted or timed out) are discarded without touching data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a byte flagged in_first; other bytes are dropped
// S_LOAD   | collecting bytes 1..FRAME_BYTES-1, inter-byte gap timer running
// S_COMMIT | one-cycle stall: shadow copied to data, in_ready held low
module led_frame_loader #(
  parameter int CLK_SPEED  = 25_000_000,
  parameter int LED_CNT    = 3,
  parameter int TIMEOUT_US = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_first,
  output logic                   in_ready,
  output logic [LED_CNT*24-1:0]  data,
  output logic                   frame_done,
  output logic                   err_abort,
  output logic                   busy
);

  localparam int     FRAME_BYTES    = LED_CNT * 3;
  // 64-bit intermediate: CLK_SPEED*TIMEOUT_US overflows 32 bits at common rates
  localparam longint TO_RAW         = (longint'(CLK_SPEED) * longint'(TIMEOUT_US)) / 64'sd1_000_000;
  localparam int     TIMEOUT_CYCLES = (TO_RAW < 1) ? 1 : int'(TO_RAW);
  localparam int     CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int     IDX_W          = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [LED_CNT*24-1:0]   r_shadow;
  logic [LED_CNT*24-1:0]   r_data;
  logic                    r_frame_done;
  logic                    r_err_abort;

  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_wr_en;
  logic                    w_wr_first;
  logic [IDX_W-1:0]        w_wr_pos;
  logic                    w_abort;
  logic                    w_commit;
  logic                    w_accept;
  logic [7:0]              w_rev;

  assign in_ready   = !reset && (r_state != S_COMMIT);
  assign busy       = (r_state == S_LOAD) || (r_state == S_COMMIT);
  assign w_accept   = in_valid && in_ready;
  assign w_wr_pos   = w_wr_first ? '0 : r_idx;
  assign data       = r_data;
  assign frame_done = r_frame_done;
  assign err_abort  = r_err_abort;

  // Driver shifts data[0] first but LEDs expect MSB first, so store each byte reversed
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 8; i++) w_rev[i] = in_data[7-i];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic plus write/abort/commit controls
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_first  = 1'b0;
    w_abort     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && in_first) begin
          w_wr_en     = 1'b1;
          w_wr_first  = 1'b1;
          w_idx_nxt   = IDX_W'(1);
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && in_first) begin
          // restart wins even on what would have been the last byte
          w_wr_en    = 1'b1;
          w_wr_first = 1'b1;
          w_idx_nxt  = IDX_W'(1);
          w_cnt_nxt  = '0;
          w_abort    = 1'b1;
        end else if (w_accept) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_COMMIT;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else if (r_cnt == CNT_LAST) begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: byte index, gap timer, shadow buffer, committed frame and pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_err_abort  <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_commit;
      r_err_abort  <= w_abort;
      if (w_wr_en)  r_shadow[{w_wr_pos, 3'b000} +: 8] <= w_rev;
      if (w_commit) r_data <= r_shadow;
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Bench for led_frame_loader: directed scenarios plus randomized traffic,
// checked every cycle against a frame-level behavioural model.
module tb_led_frame_loader;

  localparam int FB = 9;
  localparam int T  = 10;
  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_first = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data;
  logic          frame_done;
  logic          err_abort;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fd     = 0;
  int n_ea     = 0;
  bit chk_en   = 1'b0;

  led_frame_loader #(.CLK_SPEED(1_000_000), .LED_CNT(3), .TIMEOUT_US(10)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready), .data(data),
    .frame_done(frame_done), .err_abort(err_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: frames as byte lists ----------------
  logic [7:0]    m_q[$];
  bit            m_in_frame = 0;
  bit            m_pend = 0;
  int            m_gap = 0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_next = '0;
  bit            m_fd = 0;
  bit            m_ea = 0;

  function automatic logic [DW-1:0] pack_frame(input logic [7:0] b[$]);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < FB; k++)
      for (int i = 0; i < 8; i++) r[8*k+i] = b[k][7-i];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_in_frame = 0; m_pend = 0; m_gap = 0;
      m_data = '0; m_fd = 0; m_ea = 0;
    end else begin
      m_fd = 0; m_ea = 0;
      if (m_pend) begin
        m_pend = 0;
        m_data = m_next;
        m_fd   = 1;
      end else if (in_valid && in_first) begin
        if (m_in_frame) m_ea = 1;
        m_q.delete();
        m_q.push_back(in_data);
        m_in_frame = 1; m_gap = 0;
      end else if (in_valid && m_in_frame) begin
        m_q.push_back(in_data);
        m_gap = 0;
        if (m_q.size() == FB) begin
          m_next = pack_frame(m_q);
          m_pend = 1; m_in_frame = 0;
        end
      end else if (!in_valid && m_in_frame) begin
        m_gap++;
        if (m_gap == T) begin
          m_in_frame = 0; m_ea = 1;
        end
      end
    end
  end

  // Compare process, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   DW'(in_ready),   DW'(!reset && !m_pend));
      chk("busy",       DW'(busy),       DW'(m_in_frame || m_pend));
      chk("frame_done", DW'(frame_done), DW'(m_fd));
      chk("err_abort",  DW'(err_abort),  DW'(m_ea));
      chk("data",       data,            m_data);
      if (frame_done) n_fd++;
      if (err_abort)  n_ea++;
    end
  end

  // ---------------- stimulus helpers (called at posedge+2) ----------------
  task automatic send(input logic [7:0] d, input bit f);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_first = f;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #2;
    end
    chk("byte_accepted", DW'(ok), DW'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    int fd0, ea0;
    logic [DW-1:0] d0;

    // 1: async reset mid-cycle for three edges
    #3 reset = 1'b1;
    #1 chk_en = 1'b1;
    chk("reset_data", data, '0);
    chk("reset_ready", DW'(in_ready), DW'(0));
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", DW'(in_ready), DW'(1));
    @(posedge clk); #2;

    // 2: single frame, MSB of byte 0 and LSB of byte 8
    fd0 = n_fd;
    send(8'h80, 1);
    for (int k = 1; k < 8; k++) send(8'h00, 0);
    send(8'h01, 0);
    idle(3);
    chk("t2_data_lit", data, 72'h80_0000_0000_0000_0001);
    chk("t2_fd_count", DW'(n_fd - fd0), DW'(1));

    // 3: stray bytes while idle
    fd0 = n_fd; ea0 = n_ea; d0 = data;
    for (int k = 0; k < 5; k++) send(8'hFF, 0);
    idle(2);
    chk("t3_data_held", data, d0);
    chk("t3_no_fd", DW'(n_fd - fd0), DW'(0));
    chk("t3_no_ea", DW'(n_ea - ea0), DW'(0));

    // 4: timeout discards partial frame, then 0xAA frame
    fd0 = n_fd; ea0 = n_ea;
    send(8'h12, 1);
    for (int k = 0; k < 3; k++) send(8'h34, 0);
    idle(12);
    chk("t4_ea_count", DW'(n_ea - ea0), DW'(1));
    chk("t4_busy_low", DW'(busy), DW'(0));
    chk("t4_data_kept", data, 72'h80_0000_0000_0000_0001);
    send(8'hAA, 1);
    for (int k = 1; k < FB; k++) send(8'hAA, 0);
    idle(3);
    chk("t4_data_lit", data, {9{8'h55}});
    chk("t4_fd_count", DW'(n_fd - fd0), DW'(1));

    // 5: restart mid-frame
    fd0 = n_fd; ea0 = n_ea;
    send(8'h77, 1);
    for (int k = 0; k < 4; k++) send(8'h66, 0);
    send(8'h0F, 1);
    for (int k = 1; k < FB; k++) send(8'h0F, 0);
    idle(3);
    chk("t5_ea_count", DW'(n_ea - ea0), DW'(1));
    chk("t5_fd_count", DW'(n_fd - fd0), DW'(1));
    chk("t5_data_lit", data, {9{8'hF0}});

    // 6: continuous valid across two frames, then reset in third
    fd0 = n_fd;
    for (int b = 1; b <= 18; b++) send(8'(b), (b == 1) || (b == 10));
    send(8'h13, 1);
    send(8'h14, 0);
    chk("t6_fd_count", DW'(n_fd - fd0), DW'(2));
    chk("t6_data_lit", data, 72'h48_88_08_F0_70_B0_30_D0_50);
    #1 reset = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    #1 chk("t6_reset_clears", data, '0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #2;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle(T + $urandom_range(0, 3));
      end else if ($urandom_range(0, 149) == 0) begin
        send(8'($urandom), 1);
        for (int k = 1; k < FB; k++) send(8'($urandom), 0);
      end else if ($urandom_range(0, 799) == 0) begin
        #1 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #2;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_first = ($urandom_range(0, 11) == 0);
        in_data  = 8'($urandom);
        @(posedge clk); #2;
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_frame_loader.md
Name: led_frame_loader

Overview:
- Upstream feeder for the WS2812 bit-serial LED driver.
- Receives a byte stream (G,R,B per LED, LED 0 first) over a valid/ready handshake and assembles it in a shadow buffer.
- On a complete frame, atomically commits it to the flat `data` vector that drives the LED driver's `data` input.
- Partial frames, whether interrupted or timed out, are discarded so the driver never shows a torn frame.

Parameters:
- CLK_SPEED, 25_000_000, clock frequency in Hz.
- LED_CNT, 3, number of LEDs. Frame length is FRAME_BYTES = LED_CNT*3.
- TIMEOUT_US, 100, maximum gap between accepted bytes inside a frame. TIMEOUT_CYCLES = CLK_SPEED*TIMEOUT_US/1_000_000, integer and at least 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_first  in  1  qualifies the current byte as byte 0 of a frame. Meaningful only with in_valid.
- in_ready  out  1  loader can accept. A byte transfers on a rising edge with in_valid && in_ready.
- data  out  LED_CNT*24  committed frame; connects to the LED driver data input.
- frame_done  out  1  one-cycle pulse when data updates.
- err_abort  out  1  one-cycle pulse when a partial frame is discarded.
- busy  out  1  high in LOAD or COMMIT.

Behaviour:
- Reset (asynchronous): state=IDLE, idx=0, timeout counter=0, shadow=0, data=0, frame_done=0, err_abort=0. in_ready is 0 while reset is asserted.
- in_ready is combinational: 1 when reset is low and state≠COMMIT.
- busy is combinational: state∈{LOAD,COMMIT}.
- Bit mapping: the driver sends data[0] first and WS2812 expects MSB first. For stream byte k: data[8k+i] = byte_k[7-i], i=0..7. Applies to both shadow and data.
- IDLE state:
  - Accepted byte with in_first=0: dropped, no pulse.
  - Accepted byte with in_first=1: shadow byte 0 written, idx←1, timeout counter←0, go to LOAD.
- LOAD state:
  - Accepted byte with in_first=0: written at idx, timeout counter←0. If idx==FRAME_BYTES-1, go to COMMIT and set idx←0; otherwise idx←idx+1.
  - Accepted byte with in_first=1: treated as a restart. Written at byte 0, idx←1, err_abort pulses next cycle, stay in LOAD. Stale shadow bytes are simply overwritten later.
  - No accepted byte: timeout counter increments. When it reaches TIMEOUT_CYCLES-1, go to IDLE, set idx←0, and pulse err_abort. data is untouched.
- COMMIT state (exactly one cycle):
  - in_ready=0; a byte offered by the source is held, not lost.
  - At the end of the cycle: data←shadow, frame_done←1 for one cycle, state←IDLE.
- Latency: final byte accepted at edge N. COMMIT occupies the cycle after N. New data and frame_done are visible after edge N+1.
- data changes only at COMMIT. It holds its value across aborts, timeouts and dropped bytes.
- frame_done and err_abort are registered. They never assert in the same cycle.
- Reset mid-LOAD: everything clears immediately, including data. No pulses.
- The timeout counter runs only in LOAD. Its width is $clog2(TIMEOUT_CYCLES+1).

Test Plan (LED_CNT=3, so FRAME_BYTES=9; CLK_SPEED=1_000_000, TIMEOUT_US=10, so 10 cycles):
1. Assert reset for 3 cycles, asynchronously mid-cycle → data=0, frame_done=0, in_ready=0 during reset. in_ready=1 on the first cycle after release.
2. Send a frame 0x80,00,00,00,00,00,00,00,01 back-to-back, in_first on byte 0 → in_ready low for exactly 1 cycle after byte 8. Then data[0]=1, data[71]=1, all other bits 0, with frame_done high for exactly 1 cycle. data stays 0 before that.
3. Send bytes 0xFF ×5 with in_first=0 while IDLE → all accepted and dropped. data unchanged, no frame_done, no err_abort, busy=0.
4. Send a frame start plus 3 bytes, then hold in_valid low for 10 cycles → err_abort pulses once, busy falls, data keeps the test-2 value. A following full frame of 0xAA×9 commits data = {9{8'h55}} (bit-reversed 0xAA).
5. Send a frame start plus 4 bytes, then a byte with in_first=1 followed by 8 more bytes (9 bytes 0x0F) → err_abort pulses at the restart. Exactly one frame_done follows, and data = {9{8'hF0}}.
6. Hold in_valid high continuously across two consecutive frames (bytes 0x01..0x12) → no byte is lost across the COMMIT stall. Second commit holds bytes 0x0A..0x12 in order. Asserting reset during the third frame clears data to 0 immediately.
